// File: rtl/multi_freq_serial_tx.sv
// Serial frame transmitter with per-bit choice between two internally timed bit periods,
// selectable bit order, latched per-frame configuration and counted/infinite repeat.
module multi_freq_serial_tx #(
   parameter int unsigned DATA_BIT = 32,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned REP_W    = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_start,
   input  logic                i_stop,
   input  logic [1:0]          i_idle_mode,
   input  logic                i_msb_first,
   input  logic [DATA_BIT-1:0] i_data,
   input  logic [DATA_BIT-1:0] i_freq_sel,
   input  logic [CNT_W-1:0]    i_div_high,
   input  logic [CNT_W-1:0]    i_div_low,
   input  logic [REP_W-1:0]    i_repeat_cnt,
   output logic                o_data,
   output logic                o_busy,
   output logic                o_frame_tick,
   output logic                o_done_tick
);

   localparam int unsigned IDX_W = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BIT - 1);

   localparam logic [1:0] MODE_LOW    = 2'd0;
   localparam logic [1:0] MODE_HIGH   = 2'd1;
   localparam logic [1:0] MODE_KEEP   = 2'd2;
   localparam logic [1:0] MODE_REPEAT = 2'd3;

   typedef enum logic {StIdle, StShift} state_e;

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [REP_W-1:0]    frames_q, frames_d;
   logic [DATA_BIT-1:0] data_q, data_d;
   logic [DATA_BIT-1:0] sel_q, sel_d;
   logic [CNT_W-1:0]    div_hi_q, div_hi_d;
   logic [CNT_W-1:0]    div_lo_q, div_lo_d;
   logic                msb_q, msb_d;
   logic [1:0]          mode_q, mode_d;
   logic [REP_W-1:0]    rep_q, rep_d;
   logic                out_q, out_d;
   logic                busy_q, busy_d;
   logic                frame_tick_q, frame_tick_d;
   logic                done_tick_q, done_tick_d;

   logic [IDX_W-1:0] cur_j, nxt_idx, nxt_j;
   logic [CNT_W-1:0] cur_div;
   logic [REP_W-1:0] frames_inc;
   logic             accept, bit_end, last_bit, frame_end, more_frames;

   function automatic logic idle_level(input logic [1:0] mode, input logic cur);
      unique case (mode)
         MODE_HIGH: return 1'b1;
         MODE_KEEP: return cur;
         default:   return 1'b0;
      endcase
   endfunction

   // Bit position k maps to data index j according to the latched bit order.
   assign cur_j       = msb_q ? (LAST_IDX - idx_q) : idx_q;
   assign nxt_idx     = idx_q + 1'b1;
   assign nxt_j       = msb_q ? (LAST_IDX - nxt_idx) : nxt_idx;
   assign cur_div     = sel_q[cur_j] ? div_hi_q : div_lo_q;
   assign bit_end     = (cnt_q == cur_div);
   assign last_bit    = (idx_q == LAST_IDX);
   assign frame_end   = bit_end && last_bit;
   assign frames_inc  = (frames_q == '1) ? frames_q : frames_q + 1'b1;
   assign more_frames = (mode_q == MODE_REPEAT) && ((rep_q == '0) || (frames_inc < rep_q));
   assign accept      = i_start && !i_stop;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         cnt_q        <= '0;
         frames_q     <= '0;
         data_q       <= '0;
         sel_q        <= '0;
         div_hi_q     <= '0;
         div_lo_q     <= '0;
         msb_q        <= 1'b0;
         mode_q       <= '0;
         rep_q        <= '0;
         out_q        <= 1'b0;
         busy_q       <= 1'b0;
         frame_tick_q <= 1'b0;
         done_tick_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         frames_q     <= frames_d;
         data_q       <= data_d;
         sel_q        <= sel_d;
         div_hi_q     <= div_hi_d;
         div_lo_q     <= div_lo_d;
         msb_q        <= msb_d;
         mode_q       <= mode_d;
         rep_q        <= rep_d;
         out_q        <= out_d;
         busy_q       <= busy_d;
         frame_tick_q <= frame_tick_d;
         done_tick_q  <= done_tick_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StShift;
         StShift: if (i_stop || (frame_end && !more_frames)) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath and registered-output next values; i_stop outranks frame end.
   always_comb begin
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      frames_d     = frames_q;
      data_d       = data_q;
      sel_d        = sel_q;
      div_hi_d     = div_hi_q;
      div_lo_d     = div_lo_q;
      msb_d        = msb_q;
      mode_d       = mode_q;
      rep_d        = rep_q;
      out_d        = out_q;
      busy_d       = busy_q;
      frame_tick_d = 1'b0;
      done_tick_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            busy_d = 1'b0;
            out_d  = idle_level(i_idle_mode, out_q);
            if (accept) begin
               data_d   = i_data;
               sel_d    = i_freq_sel;
               div_hi_d = i_div_high;
               div_lo_d = i_div_low;
               msb_d    = i_msb_first;
               mode_d   = i_idle_mode;
               rep_d    = i_repeat_cnt;
               idx_d    = '0;
               cnt_d    = '0;
               frames_d = '0;
               busy_d   = 1'b1;
               out_d    = i_msb_first ? i_data[DATA_BIT-1] : i_data[0];
            end
         end
         StShift: begin
            if (i_stop) begin
               busy_d = 1'b0;
               out_d  = idle_level(i_idle_mode, out_q);
            end else if (bit_end) begin
               cnt_d = '0;
               if (last_bit) begin
                  frame_tick_d = 1'b1;
                  frames_d     = frames_inc;
                  idx_d        = '0;
                  if (more_frames) begin
                     out_d = msb_q ? data_q[DATA_BIT-1] : data_q[0];
                  end else begin
                     busy_d      = 1'b0;
                     done_tick_d = 1'b1;
                     out_d       = idle_level(mode_q, out_q);
                  end
               end else begin
                  idx_d = nxt_idx;
                  out_d = data_q[nxt_j];
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign o_data       = out_q;
   assign o_busy       = busy_q;
   assign o_frame_tick = frame_tick_q;
   assign o_done_tick  = done_tick_q;

endmodule

// File: tb/tb_multi_freq_serial_tx.sv
// Bench for multi_freq_serial_tx: directed literal checks plus a long random run, all checked
// every cycle against a timeline model derived from frame length arithmetic.
module tb_multi_freq_serial_tx;

   localparam int unsigned DW = 8;
   localparam int unsigned CW = 4;
   localparam int unsigned RW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_start, i_stop, i_msb_first;
   logic [1:0]    i_idle_mode;
   logic [DW-1:0] i_data, i_freq_sel;
   logic [CW-1:0] i_div_high, i_div_low;
   logic [RW-1:0] i_repeat_cnt;
   logic          o_data, o_busy, o_frame_tick, o_done_tick;

   multi_freq_serial_tx #(.DATA_BIT(DW), .CNT_W(CW), .REP_W(RW)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_start      (i_start),
      .i_stop       (i_stop),
      .i_idle_mode  (i_idle_mode),
      .i_msb_first  (i_msb_first),
      .i_data       (i_data),
      .i_freq_sel   (i_freq_sel),
      .i_div_high   (i_div_high),
      .i_div_low    (i_div_low),
      .i_repeat_cnt (i_repeat_cnt),
      .o_data       (o_data),
      .o_busy       (o_busy),
      .o_frame_tick (o_frame_tick),
      .o_done_tick  (o_done_tick)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Model: time since start e, with latched configuration; outputs follow from arithmetic.
   bit            m_busy = 0;
   int            m_e = 0;
   logic          m_out = 0, m_ft = 0, m_dt = 0;
   logic [DW-1:0] l_data, l_sel;
   int            l_hi, l_lo, l_rep;
   bit            l_msb;
   logic [1:0]    l_mode;

   function automatic logic level(input logic [1:0] mode, input logic cur);
      case (mode)
         2'd1:    return 1'b1;
         2'd2:    return cur;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int pos_to_idx(input int k);
      return l_msb ? (DW - 1 - k) : k;
   endfunction

   function automatic int bit_len(input int k);
      return (l_sel[pos_to_idx(k)] ? l_hi : l_lo) + 1;
   endfunction

   function automatic logic bit_at(input int off);
      int o = off;
      for (int k = 0; k < DW; k++) begin
         if (o < bit_len(k)) return l_data[pos_to_idx(k)];
         o -= bit_len(k);
      end
      return 1'b0;
   endfunction

   task automatic model_frame();
      int len = 0;
      int nfr, f, o;
      for (int k = 0; k < DW; k++) len += bit_len(k);
      nfr = (l_mode == 2'd3) ? l_rep : 1;
      f = (m_e - 1) / len;
      o = (m_e - 1) % len;
      if (nfr == 0 || f < nfr) begin
         m_busy = 1;
         m_ft   = (o == 0 && f >= 1);
         m_dt   = 0;
         m_out  = bit_at(o);
      end else begin
         m_busy = 0;
         m_ft   = 1;
         m_dt   = 1;
         m_out  = level(l_mode, m_out);
      end
   endtask

   task automatic model_step();
      if (rst) begin
         m_busy = 0; m_out = 0; m_ft = 0; m_dt = 0;
      end else if (!m_busy) begin
         m_ft = 0; m_dt = 0;
         if (i_start && !i_stop) begin
            l_data = i_data; l_sel = i_freq_sel; l_hi = int'(i_div_high);
            l_lo = int'(i_div_low); l_msb = i_msb_first; l_mode = i_idle_mode;
            l_rep = int'(i_repeat_cnt);
            m_e = 1;
            model_frame();
         end else begin
            m_out = level(i_idle_mode, m_out);
         end
      end else if (i_stop) begin
         m_busy = 0; m_ft = 0; m_dt = 0;
         m_out = level(i_idle_mode, m_out);
      end else begin
         m_e++;
         model_frame();
      end
   endtask

   task automatic check(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: model advances on the inputs seen at the edge, DUT sampled 1 unit later.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check("model_o_data", o_data, m_out);
      check("model_o_busy", o_busy, logic'(m_busy));
      check("model_o_frame_tick", o_frame_tick, m_ft);
      check("model_o_done_tick", o_done_tick, m_dt);
   endtask

   task automatic start_frame(input logic [DW-1:0] d, input logic [DW-1:0] s, input int hi,
                              input int lo, input logic msb, input logic [1:0] mode,
                              input int rep);
      i_data = d; i_freq_sel = s; i_div_high = CW'(hi); i_div_low = CW'(lo);
      i_msb_first = msb; i_idle_mode = mode; i_repeat_cnt = RW'(rep);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   bit seq_a5[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
   int n_ft;

   initial begin
      rst = 1'b1; i_start = 0; i_stop = 0; i_idle_mode = 0; i_msb_first = 0;
      i_data = 0; i_freq_sel = 0; i_div_high = 0; i_div_low = 0; i_repeat_cnt = 0;
      tick(); tick();
      check("reset_o_data", o_data, 1'b0);
      check("reset_o_busy", o_busy, 1'b0);
      rst = 1'b0;
      tick(); tick();

      // LSB-first 0xA5, LOW
      start_frame(8'hA5, 8'h00, 0, 0, 1'b0, 2'd0, 0);
      for (int c = 1; c <= 8; c++) begin
         check("t1_bit", o_data, seq_a5[c-1]);
         tick();
      end
      check("t1_end_data", o_data, 1'b0);
      check("t1_end_frame", o_frame_tick, 1'b1);
      check("t1_end_done", o_done_tick, 1'b1);
      check("t1_end_busy", o_busy, 1'b0);
      tick(); tick();

      // MSB-first 0x01, HIGH
      start_frame(8'h01, 8'h00, 0, 0, 1'b1, 2'd1, 0);
      for (int c = 1; c <= 8; c++) begin
         check("t2_bit", o_data, logic'(c == 8));
         tick();
      end
      check("t2_end_data", o_data, 1'b1);
      check("t2_end_done", o_done_tick, 1'b1);
      tick();
      check("t2_hold_high", o_data, 1'b1);
      tick();

      // Mixed periods: 4 bits of 4 cycles, 4 bits of 2 cycles, KEEP
      start_frame(8'hFF, 8'h0F, 3, 1, 1'b0, 2'd2, 0);
      for (int c = 1; c <= 24; c++) begin
         check("t3_busy", o_busy, 1'b1);
         tick();
      end
      check("t3_done", o_done_tick, 1'b1);
      check("t3_keep", o_data, 1'b1);
      tick();
      check("t3_keep_hold", o_data, 1'b1);
      i_idle_mode = 2'd0;
      tick(); tick();

      // REPEAT x3
      start_frame(8'h81, 8'h00, 0, 0, 1'b0, 2'd3, 3);
      for (int c = 1; c <= 25; c++) begin
         check("t4_frame_tick", o_frame_tick, logic'(c == 9 || c == 17 || c == 25));
         check("t4_done_tick", o_done_tick, logic'(c == 25));
         check("t4_busy", o_busy, logic'(c <= 24));
         tick();
      end
      tick();

      // REPEAT infinite, stopped at the same edge a frame would end
      start_frame(8'h81, 8'h00, 0, 0, 1'b0, 2'd3, 0);
      n_ft = 0;
      for (int c = 1; c <= 39; c++) begin
         n_ft += int'(o_frame_tick);
         check("t5_busy", o_busy, 1'b1);
         tick();
      end
      n_vec++;
      if (n_ft != 4) begin
         n_err++;
         $display("FAIL t5_tick_count: got %0d, expected 4", n_ft);
      end
      i_stop = 1'b1; i_idle_mode = 2'd1;
      tick();
      i_stop = 1'b0;
      check("t5_stop_busy", o_busy, 1'b0);
      check("t5_stop_frame", o_frame_tick, 1'b0);
      check("t5_stop_done", o_done_tick, 1'b0);
      check("t5_stop_live_level", o_data, 1'b1);
      i_idle_mode = 2'd0;
      tick(); tick();

      // Stop at cycle 4
      start_frame(8'hA5, 8'h00, 0, 0, 1'b0, 2'd0, 0);
      tick(); tick(); tick();
      i_stop = 1'b1;
      tick();
      i_stop = 1'b0;
      check("t6_stop_busy", o_busy, 1'b0);
      check("t6_stop_frame", o_frame_tick, 1'b0);
      check("t6_stop_done", o_done_tick, 1'b0);
      tick(); tick();

      // Start held during cycles 2..8 is ignored
      start_frame(8'hA5, 8'h00, 0, 0, 1'b0, 2'd0, 0);
      tick();
      i_start = 1'b1; i_data = 8'h00;
      for (int c = 2; c <= 8; c++) begin
         check("t7_bit", o_data, seq_a5[c-1]);
         tick();
      end
      i_start = 1'b0;
      check("t7_done", o_done_tick, 1'b1);
      tick();
      check("t7_idle", o_busy, 1'b0);
      tick();

      // Reset mid-frame
      start_frame(8'hFF, 8'h00, 0, 0, 1'b0, 2'd1, 0);
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t8_rst_data", o_data, 1'b0);
      check("t8_rst_busy", o_busy, 1'b0);
      tick(); tick();

      // Inputs changed mid-frame have no effect
      start_frame(8'hA5, 8'h00, 0, 0, 1'b0, 2'd0, 0);
      i_data = 8'h5A; i_msb_first = 1'b1; i_idle_mode = 2'd1;
      i_div_high = 4'd3; i_div_low = 4'd3; i_freq_sel = 8'hFF; i_repeat_cnt = 8'd2;
      for (int c = 1; c <= 8; c++) begin
         check("t9_bit", o_data, seq_a5[c-1]);
         tick();
      end
      check("t9_end_latched_low", o_data, 1'b0);
      check("t9_done", o_done_tick, 1'b1);
      tick();
      check("t9_live_high", o_data, 1'b1);

      // Random traffic
      for (int n = 0; n < 4000; n++) begin
         rst          = ($urandom_range(0, 499) == 0);
         i_start      = ($urandom_range(0, 7) == 0);
         i_stop       = ($urandom_range(0, 59) == 0);
         i_idle_mode  = 2'($urandom_range(0, 3));
         i_msb_first  = 1'($urandom_range(0, 1));
         i_data       = DW'($urandom);
         i_freq_sel   = DW'($urandom);
         i_div_high   = CW'($urandom_range(0, 3));
         i_div_low    = CW'($urandom_range(0, 3));
         i_repeat_cnt = RW'($urandom_range(0, 3));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/multi_freq_serial_tx.md
# multi_freq_serial_tx

Parametrised successor of the single-rate serial output stage: serialises a DATA_BIT-wide word onto one pin, choosing per bit between two programmable bit periods generated internally (no external tick). It adds selectable bit order, latched per-frame configuration, a counted/infinite REPEAT mode, and busy/frame/done status. It sits between the register/control block that supplies data and divisors and the output pad.

## Interface
- DATA_BIT, 32, frame width in bits (2..64)
- CNT_W, 16, width of bit-period divisors
- REP_W, 8, width of repeat count
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- i_start  in  1  start request; accepted only when o_busy=0
- i_stop  in  1  abort current transmission; ignored when o_busy=0
- i_idle_mode  in  2  0 LOW, 1 HIGH, 2 KEEP, 3 REPEAT
- i_msb_first  in  1  1: transmit i_data[DATA_BIT-1] first; 0: LSB first
- i_data  in  DATA_BIT  frame data
- i_freq_sel  in  DATA_BIT  per data bit j: 1 uses i_div_high, 0 uses i_div_low
- i_div_high  in  CNT_W  bit period = i_div_high+1 clk cycles
- i_div_low  in  CNT_W  bit period = i_div_low+1 clk cycles
- i_repeat_cnt  in  REP_W  REPEAT mode: total frames; 0 = infinite until i_stop
- o_data  out  1  serial output (registered)
- o_busy  out  1  high while a frame sequence is in progress
- o_frame_tick  out  1  one-cycle pulse after the last bit of every completed frame
- o_done_tick  out  1  one-cycle pulse when the sequence finishes normally

## Operation
- States: IDLE, SHIFT. All outputs registered.
- IDLE: o_data follows live i_idle_mode: LOW→0, HIGH→1, KEEP→holds current o_data, REPEAT→0. o_busy=0.
- Start (IDLE and i_start=1 and i_stop=0): latch i_data, i_freq_sel, both divisors, i_msb_first, i_idle_mode, i_repeat_cnt; clear bit index, period counter, frame counter; go SHIFT. Inputs changed after acceptance have no effect until the next start.
- SHIFT: o_data = transmitted bit k (k=0..DATA_BIT-1; data index j=k for LSB-first, DATA_BIT-1-k for MSB-first). Bit held for div+1 cycles, div selected by latched freq_sel[j]. Period counter CNT_W bits, counts 0..div then wraps to 0 with index advance.
- End of last bit: o_frame_tick=1 next cycle. Then:
  - latched mode REPEAT and (repeat_cnt=0 or frames sent < repeat_cnt): restart at bit 0 from latched data with no gap; o_busy stays 1. Frame counter REP_W bits, saturating (no wrap effect in infinite mode).
  - otherwise: IDLE, o_busy=0, o_done_tick=1, o_data = latched idle level (LOW 0, HIGH 1, KEEP last bit, REPEAT 0).
- i_stop while SHIFT: next cycle IDLE, o_busy=0, o_data per live i_idle_mode; no o_frame_tick, no o_done_tick. i_stop has priority over frame end in the same cycle.
- i_start while busy ignored; i_start and i_stop together in IDLE: start ignored.
- Reset: state IDLE, o_data=0, o_busy=0, o_frame_tick=0, o_done_tick=0, all counters and latches 0. Reset mid-frame aborts with no ticks.

## Timing
- Start sampled at cycle N → cycle N+1: o_busy=1, o_data = first bit.
- Frame length = sum over bits of (div+1) cycles; with all divisors 0, bits occupy cycles N+1..N+DATA_BIT.
- Cycle N+1+length: o_frame_tick=1, and either o_done_tick=1/o_busy=0/idle level, or first bit of next repeat.
- Earliest next start: same cycle o_busy falls; its first bit appears one cycle later (one-cycle idle gap between single frames).
- Stop at cycle M → idle level and o_busy=0 at M+1.

## Test plan
- DATA_BIT=8, div_low=div_high=0, LSB-first, data 8'hA5, mode LOW, start cycle 0 → o_data 1,0,1,0,0,1,0,1 at cycles 1..8; cycle 9 o_data=0, o_frame_tick=1, o_done_tick=1, o_busy=0.
- Same with MSB-first, mode HIGH, data 8'h01 → 0×7 then 1 at cycle 8; o_data=1 from cycle 9.
- div_low=1, div_high=3, freq_sel=8'h0F, data 8'hFF → bits 0..3 held 4 cycles, bits 4..7 held 2 cycles; done at cycle 25; mode KEEP leaves o_data=1.
- Mode REPEAT, repeat_cnt=3, divisors 0, data 8'h81 → 24 contiguous bits, o_frame_tick at cycles 9,17,25, o_done_tick only at 25; repeat_cnt=0 runs until i_stop, then idle 0 with no ticks.
- i_stop at cycle 4 of a frame → cycle 5 o_busy=0, no ticks; i_start at cycles 2..8 while busy ignored; rst asserted mid-frame → o_data=0, o_busy=0 next cycle.
- Change i_data/divisors/mode during a frame → transmitted frame and end behaviour unchanged.
